// File: rtl/pulse_train_generator.sv
// Burst generator: emits N active-high pulses of programmable high/low length
// after a one-cycle start request, with busy/done handshake for sequencing.
module pulse_train_generator #(
  parameter int CNT_W = 8,
  parameter int DUR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_pulses,
  input  logic [DUR_W-1:0] high_cycles,
  input  logic [DUR_W-1:0] low_cycles,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] pulse_cnt_reg, pulse_cnt_next;
  logic [DUR_W-1:0] dur_cnt_reg, dur_cnt_next;
  logic [DUR_W-1:0] high_len_reg, high_len_next;
  logic [DUR_W-1:0] low_len_reg, low_len_next;
  logic             pulse_out_reg, pulse_out_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  // Durations are held as (length - 1) so the counter expires on zero;
  // a requested length of 0 therefore behaves exactly like 1.
  function automatic logic [DUR_W-1:0] len_m1(input logic [DUR_W-1:0] v);
    return (v == '0) ? '0 : v - DUR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      pulse_cnt_reg <= '0;
      dur_cnt_reg   <= '0;
      high_len_reg  <= '0;
      low_len_reg   <= '0;
      pulse_out_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pulse_cnt_reg <= pulse_cnt_next;
      dur_cnt_reg   <= dur_cnt_next;
      high_len_reg  <= high_len_next;
      low_len_reg   <= low_len_next;
      pulse_out_reg <= pulse_out_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pulse_cnt_next = pulse_cnt_reg;
    dur_cnt_next   = dur_cnt_reg;
    high_len_next  = high_len_reg;
    low_len_next   = low_len_reg;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          if (n_pulses == '0) begin
            done_next = 1'b1;
          end else begin
            state_next     = HIGH;
            pulse_cnt_next = n_pulses;
            high_len_next  = len_m1(high_cycles);
            low_len_next   = len_m1(low_cycles);
            dur_cnt_next   = len_m1(high_cycles);
          end
        end
      end

      HIGH: begin
        if (abort) begin
          state_next     = IDLE;
          pulse_cnt_next = '0;
          dur_cnt_next   = '0;
        end else if (dur_cnt_reg == '0) begin
          pulse_cnt_next = pulse_cnt_reg - CNT_W'(1);
          if (pulse_cnt_reg == CNT_W'(1)) begin
            state_next   = IDLE;
            dur_cnt_next = '0;
            done_next    = 1'b1;
          end else begin
            state_next   = LOW;
            dur_cnt_next = low_len_reg;
          end
        end else begin
          dur_cnt_next = dur_cnt_reg - DUR_W'(1);
        end
      end

      LOW: begin
        if (abort) begin
          state_next     = IDLE;
          pulse_cnt_next = '0;
          dur_cnt_next   = '0;
        end else if (dur_cnt_reg == '0) begin
          state_next   = HIGH;
          dur_cnt_next = high_len_reg;
        end else begin
          dur_cnt_next = dur_cnt_reg - DUR_W'(1);
        end
      end

      default: begin
        state_next     = IDLE;
        pulse_cnt_next = '0;
        dur_cnt_next   = '0;
      end
    endcase

    // Outputs are registered versions of the next state, so they change only on clock edges.
    pulse_out_next = (state_next == HIGH);
    busy_next      = (state_next != IDLE);
  end

  assign pulse_out = pulse_out_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed self-checking bench for pulse_train_generator; bit j of each
// captured vector holds the output observed in cycle T+j after a start at T.
module tb_pulse_train_generator;

  localparam int CNT_W = 8;
  localparam int DUR_W = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] n_pulses;
  logic [DUR_W-1:0] high_cycles;
  logic [DUR_W-1:0] low_cycles;
  logic             pulse_out;
  logic             busy;
  logic             done;

  int checks = 0;
  int fails  = 0;

  pulse_train_generator #(.CNT_W(CNT_W), .DUR_W(DUR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .n_pulses    (n_pulses),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requests a burst in cycle T, then samples cycles T+1..T+ncyc on negedges.
  // Optional events (cycle index 0 = none): second start, abort, n_pulses change.
  task automatic run_burst(input int n, input int h, input int l, input int ncyc,
                           input int restart_at, input int abort_at, input int newn_at,
                           output logic [31:0] p, output logic [31:0] b,
                           output logic [31:0] d, output int falls);
    logic prev;
    p = '0; b = '0; d = '0; falls = 0; prev = 1'b0;
    @(negedge clk);
    n_pulses    = CNT_W'(n);
    high_cycles = DUR_W'(h);
    low_cycles  = DUR_W'(l);
    start       = 1'b1;
    abort       = 1'b0;
    for (int j = 1; j <= ncyc; j++) begin
      @(negedge clk);
      p[j] = pulse_out;
      b[j] = busy;
      d[j] = done;
      if (prev && !pulse_out) falls++;
      prev  = pulse_out;
      start = (j == restart_at);
      abort = (j == abort_at);
      if (j == newn_at) n_pulses = 8'd9;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset;
    int bad;
    bad = 0;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = ~start;
      if (pulse_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    start = 1'b0;
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL reset_hold: %0d cycles with nonzero outputs, required 0", bad);
    end
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pulse_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL reset_release: %0d cycles of activity after release, required 0", bad);
    end
    $display("reset test complete");
  endtask

  task automatic test_basic;
    logic [31:0] p, b, d;
    int f;
    run_burst(3, 2, 3, 16, 0, 0, 0, p, b, d, f);
    checks++;
    if (p !== 32'h0000_18C6) begin fails++; $display("FAIL basic_pulse: got %h, required %h", p, 32'h18C6); end
    checks++;
    if (b !== 32'h0000_1FFE) begin fails++; $display("FAIL basic_busy: got %h, required %h", b, 32'h1FFE); end
    checks++;
    if (d !== 32'h0000_2000) begin fails++; $display("FAIL basic_done: got %h, required %h", d, 32'h2000); end
    checks++;
    if (f !== 3) begin fails++; $display("FAIL basic_falls: got %0d, required 3", f); end
    $display("basic burst: pulse=%h busy=%h done=%h falls=%0d", p, b, d, f);
  endtask

  task automatic test_zero_values;
    logic [31:0] p, b, d;
    int f;
    run_burst(0, 5, 5, 5, 0, 0, 0, p, b, d, f);
    checks++;
    if (p !== 32'h0 || b !== 32'h0) begin
      fails++; $display("FAIL zero_n_activity: pulse=%h busy=%h, required 0/0", p, b);
    end
    checks++;
    if (d !== 32'h2) begin fails++; $display("FAIL zero_n_done: got %h, required %h", d, 32'h2); end
    $display("zero pulses: pulse=%h busy=%h done=%h", p, b, d);

    run_burst(2, 0, 0, 6, 0, 0, 0, p, b, d, f);
    checks++;
    if (p !== 32'hA) begin fails++; $display("FAIL degen_pulse: got %h, required %h", p, 32'hA); end
    checks++;
    if (b !== 32'hE) begin fails++; $display("FAIL degen_busy: got %h, required %h", b, 32'hE); end
    checks++;
    if (d !== 32'h10) begin fails++; $display("FAIL degen_done: got %h, required %h", d, 32'h10); end
    $display("zero durations: pulse=%h busy=%h done=%h", p, b, d);
  endtask

  task automatic test_ignored_start;
    logic [31:0] p, b, d;
    int f;
    run_burst(4, 1, 1, 10, 3, 0, 2, p, b, d, f);
    checks++;
    if (p !== 32'hAA) begin fails++; $display("FAIL ignore_pulse: got %h, required %h", p, 32'hAA); end
    checks++;
    if (b !== 32'hFE) begin fails++; $display("FAIL ignore_busy: got %h, required %h", b, 32'hFE); end
    checks++;
    if (d !== 32'h100) begin fails++; $display("FAIL ignore_done: got %h, required %h", d, 32'h100); end
    checks++;
    if (f !== 4) begin fails++; $display("FAIL ignore_falls: got %0d, required 4", f); end
    $display("ignored start: pulse=%h busy=%h done=%h falls=%0d", p, b, d, f);
  endtask

  task automatic test_back_to_back;
    logic [31:0] p, b, d;
    int f;
    run_burst(1, 2, 1, 8, 3, 0, 0, p, b, d, f);
    checks++;
    if (p !== 32'h36) begin fails++; $display("FAIL b2b_pulse: got %h, required %h", p, 32'h36); end
    checks++;
    if (b !== 32'h36) begin fails++; $display("FAIL b2b_busy: got %h, required %h", b, 32'h36); end
    checks++;
    if (d !== 32'h48) begin fails++; $display("FAIL b2b_done: got %h, required %h", d, 32'h48); end
    $display("back to back: pulse=%h busy=%h done=%h", p, b, d);
  endtask

  task automatic test_abort;
    logic [31:0] p, b, d;
    int f;
    int bad;
    run_burst(5, 4, 4, 16, 0, 6, 0, p, b, d, f);
    checks++;
    if (p !== 32'h1E) begin fails++; $display("FAIL abort_pulse: got %h, required %h", p, 32'h1E); end
    checks++;
    if (b !== 32'h7E) begin fails++; $display("FAIL abort_busy: got %h, required %h", b, 32'h7E); end
    checks++;
    if (d !== 32'h0) begin fails++; $display("FAIL abort_done: got %h, required %h", d, 32'h0); end
    $display("abort mid-burst: pulse=%h busy=%h done=%h", p, b, d);

    // abort together with start in IDLE
    @(negedge clk);
    n_pulses = 8'd2; high_cycles = 16'd1; low_cycles = 16'd1;
    start = 1'b1; abort = 1'b1;
    bad = 0;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (pulse_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL abort_start_idle: %0d active cycles, required 0", bad); end
    $display("abort with start in idle: active cycles=%0d", bad);

    // asynchronous reset mid-burst
    @(negedge clk);
    n_pulses = 8'd3; high_cycles = 16'd4; low_cycles = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (pulse_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: pulse=%b busy=%b done=%b, required 0/0/0", pulse_out, busy, done);
    end
    $display("async reset mid-burst: pulse=%b busy=%b done=%b", pulse_out, busy, done);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    n_pulses = '0; high_cycles = '0; low_cycles = '0;
    test_reset();
    test_basic();
    test_zero_values();
    test_ignored_start();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pulse_train_generator.md
# pulse_train_generator

Generates a burst of N clean, active-high pulses with programmable high and low durations on a single output, started by a one-cycle request. It is the stimulus side of the pulse-adder path. A falling-edge detector on `pulse_out` sees exactly N falling edges per burst, one at the end of each pulse. Handshake outputs `busy` and `done` let a controller sequence bursts back to back.

## Interface
- `CNT_W`, default 8: width of the pulse-count input.
- `DUR_W`, default 16: width of the high/low duration inputs, in clock cycles.

Ports:
- `clk`  in  1  system clock, rising-edge active.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  burst request; sampled on the rising edge of `clk`.
- `abort`  in  1  synchronous burst cancel.
- `n_pulses`  in  CNT_W  number of pulses in the burst.
- `high_cycles`  in  DUR_W  cycles `pulse_out` stays high per pulse.
- `low_cycles`  in  DUR_W  cycles `pulse_out` stays low between pulses.
- `pulse_out`  out  1  pulse train; registered.
- `busy`  out  1  burst in progress; registered.
- `done`  out  1  one-cycle completion strobe; registered.

## Operation
- **Reset.** Asserting `rst` (low) immediately forces state IDLE and all counters to 0, and drives `pulse_out`=0, `busy`=0, `done`=0.
- **State machine.** States are IDLE, HIGH and LOW.
- **IDLE.** `pulse_out`=0, `busy`=0.
  - `start`=1, `abort`=0, `n_pulses`≠0: latch all three configuration inputs, go to HIGH.
  - `start`=1, `n_pulses`=0: stay in IDLE and pulse `done` for one cycle. No pulse is emitted and `busy` stays 0.
- **HIGH.** `pulse_out`=1 for H cycles.
  - Then, if pulses remain, go to LOW.
  - Otherwise go to IDLE, with `done`=1 for that first IDLE cycle.
- **LOW.** `pulse_out`=0 for L cycles, then go to HIGH.
- **Duration values.** H = max(`high_cycles`,1) and L = max(`low_cycles`,1). A latched value of 0 is treated as 1, so pulses and gaps are never zero-length.
- **Latching.** Configuration is captured only when a start is accepted. Changes to `n_pulses`, `high_cycles` or `low_cycles` while `busy`=1 have no effect on the current burst.
- **Start while busy.** `start` is ignored while `busy`=1. No queuing.
- **Start on the done cycle.** `busy`=0 in the `done` cycle, so a `start` there is accepted. Back-to-back bursts are separated by exactly one low cycle.
- **Abort.**
  - `abort`=1 while `busy`=1: next cycle `pulse_out`=0, `busy`=0, `done`=0, state IDLE, counters cleared.
  - `abort` in IDLE is ignored.
  - `abort` and `start` in the same IDLE cycle: abort wins and the start is dropped.
- **Counters.** The pulse counter is CNT_W bits, loaded with N and decremented at the end of each HIGH phase. The duration counter is DUR_W bits. Neither counter wraps; the maximum burst is (2^CNT_W−1) pulses of (2^DUR_W−1) cycles each.

## Timing
All timing is measured from a start accepted at edge T.
- **Pulse k** (k = 1..N): `pulse_out`=1 in cycles T+1+(k−1)(H+L) through T+(k−1)(H+L)+H.
- **Gaps:** `pulse_out`=0 in each L-cycle gap between pulses.
- **Busy:** `busy`=1 from cycle T+1 through T+N·H+(N−1)·L.
- **Done:** `done`=1 only in cycle T+N·H+(N−1)·L+1, where `busy`=0 and `pulse_out`=0.
- **Latency:** start to first rising edge of `pulse_out` is 1 cycle.
- **Zero-pulse request:** `done` at T+1 only.
- **Glitch-free output:** all outputs come straight from flops, and `pulse_out` never toggles within a cycle.

## Test plan
- **Reset.** Hold `rst`=0 and toggle `start`; then release `rst` → `pulse_out`, `busy` and `done` stay 0 throughout, and no activity follows release without a new `start`.
- **Basic burst.** `n_pulses`=3, `high_cycles`=2, `low_cycles`=3, start at T → `pulse_out` high at T+1..2, T+6..7 and T+11..12; `busy` high at T+1..T+12; `done` high at T+13 only. A negedge detector counts 3.
- **Zero and degenerate values.**
  - `n_pulses`=0 → `done` at T+1, `pulse_out` and `busy` stay 0.
  - `n_pulses`=2, `high_cycles`=0, `low_cycles`=0 → `pulse_out` high at T+1 and T+3, `done` at T+4.
- **Ignored start and config change.** `n_pulses`=4, H=L=1. Pulse `start` again at T+3 and change `n_pulses` to 9 mid-burst → exactly 4 pulses, `done` at T+8.
- **Back-to-back bursts.** Issue `start` in the `done` cycle of a 1-pulse, H=2 burst → second burst's `pulse_out` rises one cycle after that `done` cycle, with exactly one low cycle between the bursts.
- **Abort.**
  - `n_pulses`=5, H=4, L=4, `abort` at T+6 → from T+7, `pulse_out`=0 and `busy`=0, with no `done`.
  - `abort` and `start` together in IDLE → no burst.
  - `rst` low mid-burst → outputs 0 immediately, asynchronously.
